coin_dispatcher: RTL and testbench

- Game-side controller for the coin lane sprites (left/centre/right).
- Picks a lane pseudo-randomly and raises that lane's `active`. It then waits for the coin's `in_position`, opens a frame-counted hit window, and judges the player's button press as hit or miss.
- Retires the coin by dropping `active` for at least one frame, so the sprite re-homes on its next v-sync.
- Drives score and miss counters to the HUD.

---
 rtl/coin_dispatcher.sv | 174 +++++++++++++++++
 tb/tb_coin_dispatcher.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_dispatcher.sv
// Coin lane dispatcher: spawns a coin on a pseudo-random lane, judges the
// player's press inside a frame-counted window and keeps the HUD score/miss counts.
//
// state  | meaning
// IDLE   | game stopped, no coin on screen
// GAP    | counting frames before the next spawn
// TRAVEL | coin active, waiting for in_position (timeout = miss)
// WINDOW | hit window open, judging presses
// RETIRE | coin dropped, waiting one v-sync so the sprite re-homes
module coin_dispatcher #(
  parameter int          NUM_LANES      = 3,
  parameter int          SPAWN_GAP      = 30,
  parameter int          TRAVEL_TIMEOUT = 64,
  parameter int          HIT_WINDOW     = 8,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_frame_tick,
  input  logic                 i_enable,
  input  logic [NUM_LANES-1:0] i_in_position,
  input  logic [NUM_LANES-1:0] i_btn,
  output logic [NUM_LANES-1:0] o_active,
  output logic [15:0]          o_score,
  output logic [7:0]           o_misses,
  output logic                 o_hit_pulse,
  output logic                 o_miss_pulse,
  output logic                 o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_TRAVEL,
    S_WINDOW,
    S_RETIRE
  } state_t;

  localparam int GAP_TO_MAX = (SPAWN_GAP > TRAVEL_TIMEOUT) ? SPAWN_GAP : TRAVEL_TIMEOUT;
  localparam int CNT_MAX    = (GAP_TO_MAX > HIT_WINDOW) ? GAP_TO_MAX : HIT_WINDOW;
  localparam int CW         = $clog2(CNT_MAX + 1);
  localparam logic [NUM_LANES-1:0] LANE0 = {{(NUM_LANES-1){1'b0}}, 1'b1};

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [1:0]           lane, lane_nxt, lane_pick;
  logic [15:0]          lfsr, lfsr_adv;
  logic [NUM_LANES-1:0] btn_q, pos_q, press;
  logic [NUM_LANES-1:0] lane_mask, pick_mask, active_nxt;
  logic                 cnt_done, pos_sel, pos_fell, press_lane, press_wrong;
  logic                 hit, miss;
  logic [15:0]          score_nxt;
  logic [7:0]           misses_nxt;

  assign lfsr_adv = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // lfsr[1:0] is below 4 and NUM_LANES is at least 2, so one subtraction is a full modulo
  always_comb begin
    lane_pick = lfsr[1:0];
    if ({1'b0, lfsr[1:0]} >= 3'(NUM_LANES)) begin
      lane_pick = lfsr[1:0] - 2'(NUM_LANES);
    end
  end

  assign lane_mask   = LANE0 << lane;
  assign pick_mask   = LANE0 << lane_pick;
  assign press       = i_btn & ~btn_q;
  assign pos_sel     = |(i_in_position & lane_mask);
  assign pos_fell    = |(pos_q & lane_mask) & ~pos_sel;
  assign press_lane  = |(press & lane_mask);
  assign press_wrong = |(press & ~lane_mask);
  assign cnt_done    = i_frame_tick && (cnt == CW'(1));

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = (i_frame_tick && (cnt != '0)) ? cnt - CW'(1) : cnt;
    lane_nxt   = lane;
    active_nxt = '0;
    hit        = 1'b0;
    miss       = 1'b0;

    if (!i_enable) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_GAP;
          cnt_nxt   = CW'(SPAWN_GAP);
        end
        S_GAP: begin
          if (cnt_done) begin
            lane_nxt   = lane_pick;
            active_nxt = pick_mask;
            cnt_nxt    = CW'(TRAVEL_TIMEOUT);
            state_nxt  = S_TRAVEL;
          end
        end
        S_TRAVEL: begin
          active_nxt = lane_mask;
          if (pos_sel) begin
            cnt_nxt   = CW'(HIT_WINDOW);
            state_nxt = S_WINDOW;
          end else if (cnt_done) begin
            miss       = 1'b1;
            active_nxt = '0;
            state_nxt  = S_RETIRE;
          end
        end
        S_WINDOW: begin
          active_nxt = lane_mask;
          // a wrong-lane press loses even when the right lane is pressed together
          if (press_wrong) begin
            miss = 1'b1;
          end else if (press_lane) begin
            hit = 1'b1;
          end else if (pos_fell || cnt_done) begin
            miss = 1'b1;
          end
          if (hit || miss) begin
            active_nxt = '0;
            state_nxt  = S_RETIRE;
          end
        end
        S_RETIRE: begin
          if (i_frame_tick) begin
            cnt_nxt   = CW'(SPAWN_GAP);
            state_nxt = S_GAP;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign score_nxt  = (hit && (o_score != 16'hFFFF)) ? o_score + 16'd1 : o_score;
  assign misses_nxt = (miss && (o_misses != 8'hFF)) ? o_misses + 8'd1 : o_misses;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      lane         <= '0;
      lfsr         <= LFSR_SEED;
      btn_q        <= '1;
      pos_q        <= '0;
      o_active     <= '0;
      o_score      <= '0;
      o_misses     <= '0;
      o_hit_pulse  <= 1'b0;
      o_miss_pulse <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      lane         <= lane_nxt;
      if (i_frame_tick && (state != S_IDLE)) begin
        lfsr <= lfsr_adv;
      end
      btn_q        <= i_btn;
      pos_q        <= i_in_position;
      o_active     <= active_nxt;
      o_score      <= score_nxt;
      o_misses     <= misses_nxt;
      o_hit_pulse  <= hit;
      o_miss_pulse <= miss;
      o_busy       <= (state_nxt == S_TRAVEL) || (state_nxt == S_WINDOW);
    end
  end

endmodule

// File: tb/tb_coin_dispatcher.sv
// Self-checking bench for coin_dispatcher: directed rounds with randomised timing,
// lanes and outcomes, checked against a frame-level game model.
module tb_coin_dispatcher;

  localparam int          NL   = 3;
  localparam int          GAP  = 2;
  localparam int          TO   = 5;
  localparam int          WIN  = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          i_clk = 1'b0;
  logic          i_rst, i_frame_tick, i_enable;
  logic [NL-1:0] i_in_position, i_btn, o_active;
  logic [15:0]   o_score;
  logic [7:0]    o_misses;
  logic          o_hit_pulse, o_miss_pulse, o_busy;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] lfsr_m;
  logic [15:0] score_m;
  logic [7:0]  misses_m;
  bit          running_m;

  always #5 i_clk = ~i_clk;

  coin_dispatcher #(
    .NUM_LANES(NL), .SPAWN_GAP(GAP), .TRAVEL_TIMEOUT(TO), .HIT_WINDOW(WIN), .LFSR_SEED(SEED)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_frame_tick(i_frame_tick), .i_enable(i_enable),
    .i_in_position(i_in_position), .i_btn(i_btn), .o_active(o_active),
    .o_score(o_score), .o_misses(o_misses), .o_hit_pulse(o_hit_pulse),
    .o_miss_pulse(o_miss_pulse), .o_busy(o_busy)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
  endfunction

  function automatic int pick_lane();
    return int'(lfsr_m[1:0]) % NL;
  endfunction

  function automatic logic [NL-1:0] oh(input int l);
    return NL'(1) << l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock; eh/em = judged hit/miss expected at this edge, act = expected o_active after it
  task automatic step(input bit tk, input bit eh, input bit em, input logic [NL-1:0] act);
    i_frame_tick = tk;
    @(posedge i_clk);
    @(negedge i_clk);
    i_frame_tick = 1'b0;
    if (tk && running_m) lfsr_m = lfsr_next(lfsr_m);
    if (eh && score_m != 16'hFFFF) score_m = score_m + 16'd1;
    if (em && misses_m != 8'hFF) misses_m = misses_m + 8'd1;
    chk("hit_pulse",  32'(o_hit_pulse),  32'(eh));
    chk("miss_pulse", 32'(o_miss_pulse), 32'(em));
    chk("score",      32'(o_score),      32'(score_m));
    chk("misses",     32'(o_misses),     32'(misses_m));
    chk("active",     32'(o_active),     32'(act));
    chk("busy",       32'(o_busy),       32'(|act));
  endtask

  task automatic idle_rand(input logic [NL-1:0] act);
    repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 1'b0, act);
  endtask

  task automatic spawn(output int ln);
    ln = 0;
    for (int k = 1; k <= GAP; k++) begin
      idle_rand('0);
      if (k == GAP) begin
        ln = pick_lane();
        step(1'b1, 1'b0, 1'b0, oh(ln));
      end else begin
        step(1'b1, 1'b0, 1'b0, '0);
      end
    end
  endtask

  task automatic ticks_then_miss(input int n, input logic [NL-1:0] a);
    for (int k = 1; k <= n; k++) begin
      idle_rand(a);
      if (k == n) step(1'b1, 1'b0, 1'b1, '0);
      else        step(1'b1, 1'b0, 1'b0, a);
    end
  endtask

  task automatic safe_ticks(input int n, input logic [NL-1:0] a);
    for (int k = 0; k < n; k++) begin
      idle_rand(a);
      step(1'b1, 1'b0, 1'b0, a);
    end
  endtask

  task automatic enter_window(input logic [NL-1:0] a);
    i_in_position = i_in_position | a;
    step(1'b0, 1'b0, 1'b0, a);
  endtask

  // kinds: 0 hit, 1 window expiry, 2 right+wrong press, 3 wrong press,
  //        4 button held from travel, 5 travel timeout, 6 in_position drop
  task automatic round(input int kind, input bit noise);
    int ln, w;
    logic [NL-1:0] a;
    spawn(ln);
    a = oh(ln);
    w = (ln + 1 + int'($urandom_range(0, NL - 2))) % NL;
    i_in_position = NL'($urandom) & ~a;
    if (noise && $urandom_range(0, 1) == 1) begin
      i_btn = oh(w) | a;
      step(1'b0, 1'b0, 1'b0, a);
      i_btn = '0;
      step(1'b0, 1'b0, 1'b0, a);
    end
    if (kind == 5) begin
      ticks_then_miss(TO, a);
    end else begin
      safe_ticks(int'($urandom_range(0, TO - 2)), a);
      if (kind == 4) begin
        i_btn = a;
        step(1'b0, 1'b0, 1'b0, a);
      end
      enter_window(a);
      case (kind)
        0: begin
          safe_ticks(int'($urandom_range(0, WIN - 1)), a);
          i_btn = a;
          step(1'b0, 1'b1, 1'b0, '0);
        end
        2: begin
          i_btn = a | oh(w);
          step(1'b0, 1'b0, 1'b1, '0);
        end
        3: begin
          i_btn = oh(w);
          step(1'b0, 1'b0, 1'b1, '0);
        end
        6: begin
          safe_ticks(int'($urandom_range(0, WIN - 1)), a);
          i_in_position = i_in_position & ~a;
          step(1'b0, 1'b0, 1'b1, '0);
        end
        default: ticks_then_miss(WIN, a);
      endcase
    end
    i_btn         = '0;
    i_in_position = '0;
    idle_rand('0);
    step(1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    int ln;
    logic [NL-1:0] a;
    i_rst = 1'b0; i_frame_tick = 1'b0; i_enable = 1'b0;
    i_in_position = '0; i_btn = '0;
    lfsr_m = SEED; score_m = '0; misses_m = '0; running_m = 1'b0;
    #1 i_rst = 1'b1;
    #1;
    chk("rst_active", 32'(o_active), 32'd0);
    chk("rst_score",  32'(o_score),  32'd0);
    chk("rst_misses", 32'(o_misses), 32'd0);
    chk("rst_pulses", 32'({o_hit_pulse, o_miss_pulse, o_busy}), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);

    i_enable = 1'b1;
    step(1'b0, 1'b0, 1'b0, '0);
    running_m = 1'b1;
    round(0, 1'b0);
    round(1, 1'b0);
    round(2, 1'b0);
    round(4, 1'b0);
    round(5, 1'b0);
    round(6, 1'b0);
    round(3, 1'b0);

    // abort while the window is open
    spawn(ln);
    a = oh(ln);
    enter_window(a);
    i_enable = 1'b0;
    step(1'(($urandom_range(0, 1))), 1'b0, 1'b0, '0);
    running_m = 1'b0;
    i_in_position = '0;
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    i_enable = 1'b1;
    step(1'b0, 1'b0, 1'b0, '0);
    running_m = 1'b1;
    round(0, 1'b1);

    // asynchronous reset mid-travel, with every button held through it
    spawn(ln);
    step(1'b0, 1'b0, 1'b0, oh(ln));
    i_btn = '1;
    #2 i_rst = 1'b1;
    #1;
    chk("arst_active", 32'(o_active), 32'd0);
    chk("arst_score",  32'(o_score),  32'd0);
    chk("arst_misses", 32'(o_misses), 32'd0);
    chk("arst_flags",  32'({o_hit_pulse, o_miss_pulse, o_busy}), 32'd0);
    lfsr_m = SEED; score_m = '0; misses_m = '0; running_m = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, '0);
    running_m = 1'b1;
    spawn(ln);
    a = oh(ln);
    enter_window(a);
    ticks_then_miss(WIN, a);
    i_btn = '0;
    i_in_position = '0;
    step(1'b1, 1'b0, 1'b0, '0);

    repeat (25) round(int'($urandom_range(0, 6)), 1'b1);

    // saturation: preload counters just below their ceilings
    force dut.o_score  = 16'hFFFE;
    force dut.o_misses = 8'hFE;
    score_m  = 16'hFFFE;
    misses_m = 8'hFE;
    step(1'b0, 1'b0, 1'b0, '0);
    release dut.o_score;
    release dut.o_misses;
    step(1'b0, 1'b0, 1'b0, '0);
    round(0, 1'b0);
    round(0, 1'b1);
    round(1, 1'b0);
    round(3, 1'b1);
    round(5, 1'b0);
    chk("score_sat",  32'(o_score),  32'h0000FFFF);
    chk("misses_sat", 32'(o_misses), 32'h000000FF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
